load_store_queue: RTL and testbench

//  In-order circular queue holding loads/stores between dispatch and the memory controller.

---
 rtl/load_store_queue_pkg.sv | 26 ++
 rtl/load_store_queue.sv | 107 ++++++++++
 tb/tb_load_store_queue.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/load_store_queue_pkg.sv
// Shared types for the load/store queue: the memory-side packet and the
// per-entry bookkeeping record.
package load_store_queue_pkg;

  localparam int LSQ_DEPTH = 8;
  localparam int LSQ_ROB_W = 4;

  // Head packet handed to the memory controller
  typedef struct packed {
    logic [31:0]          address;
    logic [31:0]          result;
    logic [LSQ_ROB_W-1:0] ROB_entry;
  } lsq_packet_t;

  // One queue slot
  typedef struct packed {
    logic                 valid;
    logic                 is_load;
    logic                 addr_ok;
    logic                 issued;
    logic [LSQ_ROB_W-1:0] ROB_entry;
    logic [31:0]          address;
    logic [31:0]          result;
  } lsq_entry_t;

endpackage

// File: rtl/load_store_queue.sv
// In-order circular load/store queue. Dispatch allocates at the tail, the AGU
// fills address/data by index, the memory controller consumes the head.
module load_store_queue
  import load_store_queue_pkg::*;
#(
  parameter int DEPTH = LSQ_DEPTH,
  parameter int IDX_W = $clog2(DEPTH),
  parameter int ROB_W = LSQ_ROB_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              enq_valid,
  input  logic              enq_is_load,
  input  logic [ROB_W-1:0]  enq_rob_entry,
  output logic [IDX_W-1:0]  enq_idx,
  output logic              full,
  output logic              empty,
  output logic [IDX_W:0]    count,
  input  logic              agu_valid,
  input  logic [IDX_W-1:0]  agu_idx,
  input  logic [31:0]       agu_address,
  input  logic [31:0]       agu_data,
  input  logic              rd_en,
  output logic              head_load,
  output logic              head_ready,
  output lsq_packet_t       mem_out
);

  lsq_entry_t       q [DEPTH];
  logic [IDX_W-1:0] head_ptr;
  logic [IDX_W-1:0] tail_ptr;
  lsq_entry_t       hd;
  logic             do_enq;
  logic             do_deq;
  logic             do_issue;
  logic             agu_hit;

  assign hd    = q[head_ptr];
  assign full  = (count == (IDX_W+1)'(DEPTH));
  assign empty = (count == '0);

  assign enq_idx    = tail_ptr;
  assign head_ready = hd.valid & hd.addr_ok & ~hd.issued;
  assign head_load  = hd.valid & hd.is_load;

  // Head packet; zeroed while the head slot is empty
  always_comb begin
    mem_out = '0;
    if (hd.valid) begin
      mem_out.address   = hd.address;
      mem_out.result    = hd.result;
      mem_out.ROB_entry = hd.ROB_entry;
    end
  end

  // Full is sampled before this cycle's dequeue, so a full queue never
  // refills the slot being freed in the same cycle.
  always_comb begin
    do_enq   = enq_valid & ~full;
    do_deq   = rd_en & ~empty;
    do_issue = head_load & head_ready;
    // A dequeue of the head wins over an AGU write to it
    agu_hit  = agu_valid & q[agu_idx].valid & ~(do_deq & (agu_idx == head_ptr));
  end

  // Entry array and pointer/count state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      if (agu_hit) begin
        q[agu_idx].address <= agu_address;
        if (!q[agu_idx].is_load) q[agu_idx].result <= agu_data;
        q[agu_idx].addr_ok <= 1'b1;
      end
      // A load is presented once; the controller keeps the data until rd_en
      if (do_issue) q[head_ptr].issued <= 1'b1;
      if (do_deq) begin
        q[head_ptr].valid <= 1'b0;
        head_ptr          <= head_ptr + 1'b1;
      end
      // Fresh entries start with cleared address/result so mem_out is clean
      if (do_enq) begin
        q[tail_ptr].valid     <= 1'b1;
        q[tail_ptr].is_load   <= enq_is_load;
        q[tail_ptr].addr_ok   <= 1'b0;
        q[tail_ptr].issued    <= 1'b0;
        q[tail_ptr].ROB_entry <= enq_rob_entry;
        q[tail_ptr].address   <= '0;
        q[tail_ptr].result    <= '0;
        tail_ptr              <= tail_ptr + 1'b1;
      end
      if (do_enq && !do_deq)      count <= count + 1'b1;
      else if (!do_enq && do_deq) count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_load_store_queue.sv
// Directed scenarios followed by random traffic, checked against a
// queue-based reference model of the LSQ.
module tb_load_store_queue;
  import load_store_queue_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, enq_valid, enq_is_load, agu_valid, rd_en;
  logic [3:0]  enq_rob_entry;
  logic [2:0]  enq_idx, agu_idx;
  logic        full, empty, head_load, head_ready;
  logic [3:0]  count;
  logic [31:0] agu_address, agu_data;
  lsq_packet_t mem_out;

  int vecs  = 0;
  int fails = 0;

  load_store_queue dut (
    .clk(clk), .reset(reset), .flush(flush),
    .enq_valid(enq_valid), .enq_is_load(enq_is_load), .enq_rob_entry(enq_rob_entry),
    .enq_idx(enq_idx), .full(full), .empty(empty), .count(count),
    .agu_valid(agu_valid), .agu_idx(agu_idx), .agu_address(agu_address), .agu_data(agu_data),
    .rd_en(rd_en), .head_load(head_load), .head_ready(head_ready), .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  // Reference model: program-ordered list of live ops, head at [0]
  typedef struct {
    int        idx;
    bit        is_load;
    bit [3:0]  rob;
    bit        addr_ok;
    bit        issued;
    bit [31:0] addr;
    bit [31:0] data;
  } m_ent_t;

  m_ent_t mq[$];
  int     mhead = 0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int     sz;
    bit     isfull, deq, issue;
    int     tail;
    m_ent_t e;
    sz = mq.size();
    if (reset || flush) begin
      mq.delete();
      mhead = 0;
      return;
    end
    isfull = (sz == 8);
    deq    = rd_en && sz > 0;
    issue  = sz > 0 && mq[0].is_load && mq[0].addr_ok && !mq[0].issued;
    tail   = (mhead + sz) % 8;
    if (agu_valid) begin
      for (int i = 0; i < sz; i++) begin
        if (mq[i].idx == int'(agu_idx) && !(deq && i == 0)) begin
          mq[i].addr    = agu_address;
          if (!mq[i].is_load) mq[i].data = agu_data;
          mq[i].addr_ok = 1'b1;
        end
      end
    end
    if (issue) mq[0].issued = 1'b1;
    if (deq) begin
      void'(mq.pop_front());
      mhead = (mhead + 1) % 8;
    end
    if (enq_valid && !isfull) begin
      e = '{idx: tail, is_load: enq_is_load, rob: enq_rob_entry,
            addr_ok: 1'b0, issued: 1'b0, addr: 32'h0, data: 32'h0};
      mq.push_back(e);
    end
  endtask

  task automatic check_all();
    int          sz;
    logic [67:0] exp_pkt;
    sz = mq.size();
    exp_pkt = '0;
    if (sz > 0) exp_pkt = {mq[0].addr, mq[0].data, mq[0].rob};
    chk("count",      96'(count),      96'(sz));
    chk("full",       96'(full),       96'(sz == 8));
    chk("empty",      96'(empty),      96'(sz == 0));
    chk("enq_idx",    96'(enq_idx),    96'((mhead + sz) % 8));
    chk("head_load",  96'(head_load),  96'(sz > 0 && mq[0].is_load));
    chk("head_ready", 96'(head_ready), 96'(sz > 0 && mq[0].addr_ok && !mq[0].issued));
    chk("mem_out",    96'(mem_out),    96'(exp_pkt));
  endtask

  // One clock: drive inputs, advance model at the edge, check 1 time unit later
  task automatic step(input bit ev, input bit il, input bit [3:0] rob,
                      input bit av, input bit [2:0] ai, input bit [31:0] aa, input bit [31:0] ad,
                      input bit rd, input bit fl, input bit rs);
    enq_valid = ev; enq_is_load = il; enq_rob_entry = rob;
    agu_valid = av; agu_idx = ai; agu_address = aa; agu_data = ad;
    rd_en = rd; flush = fl; reset = rs;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; flush = 0; enq_valid = 0; enq_is_load = 0; enq_rob_entry = 0;
    agu_valid = 0; agu_idx = 0; agu_address = 0; agu_data = 0; rd_en = 0;
    #1;
    check_all();
    chk("rst_empty", 96'(empty), 96'(1));
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Reset mid-operation with three live entries
    step(1, 1, 4'd1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 4'd2, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 4'd3, 1, 3'd0, 32'h10, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("t1_count", 96'(count), 96'(0));
    chk("t1_mem",   96'(mem_out), 96'(0));

    // Load: enqueue, address, single issue, dequeue
    step(1, 1, 4'd5, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3'd0, 32'h100, 32'h55, 0, 0, 0);
    chk("t2_ready", 96'(head_ready), 96'(1));
    chk("t2_load",  96'(head_load),  96'(1));
    chk("t2_addr",  96'(mem_out.address), 96'(32'h100));
    idle();
    chk("t2_issued", 96'(head_ready), 96'(0));
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("t2_empty", 96'(empty), 96'(1));

    // Store: stays ready until the controller dequeues it
    step(1, 0, 4'd2, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3'd1, 32'h40, 32'hDEADBEEF, 0, 0, 0);
    idle();
    idle();
    chk("t3_ready",  96'(head_ready), 96'(1));
    chk("t3_result", 96'(mem_out.result), 96'(32'hDEADBEEF));
    chk("t3_load",   96'(head_load), 96'(0));
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

    // Fill, enqueue+dequeue on full, then streaming with wraparound
    for (int i = 0; i < 8; i++) step(1, i[0], 4'(i + 8), 0, 0, 0, 0, 0, 0, 0);
    chk("t4_full", 96'(full), 96'(1));
    step(1, 0, 4'hF, 0, 0, 0, 0, 1, 0, 0);
    chk("t4_count7", 96'(count), 96'(7));
    for (int i = 0; i < 20; i++) step(1, 1, 4'(i), 0, 0, 0, 0, 1, 0, 0);

    // Flush with concurrent enqueue and dequeue
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("t6_pre4", 96'(count), 96'(4));
    step(1, 1, 4'd9, 1, 3'd0, 32'h80, 0, 1, 1, 0);
    chk("t6_count", 96'(count), 96'(0));
    chk("t6_idx",   96'(enq_idx), 96'(0));

    // Out-of-order AGU fills; in-order issue; write to invalid slot ignored
    step(1, 1, 4'd1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 4'd2, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 4'd3, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3'd2, 32'h222, 0, 0, 0, 0);
    chk("t5_notready", 96'(head_ready), 96'(0));
    step(0, 0, 0, 1, 3'd5, 32'h555, 0, 0, 0, 0);
    chk("t5_count", 96'(count), 96'(3));
    step(0, 0, 0, 1, 3'd0, 32'h200, 0, 0, 0, 0);
    chk("t5_ready", 96'(head_ready), 96'(1));

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, 4'($urandom),
           $urandom_range(0, 1) == 1, 3'($urandom), $urandom, $urandom,
           $urandom_range(0, 9) < 4, $urandom_range(0, 49) == 0, $urandom_range(0, 199) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
